corr_uart_tx: RTL and testbench
===============================

CORR_UART_TX -- requirements
Module: corr_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have a FIFO depth fixed at 4 entries of 8 bits (not a parameter).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 value  input  8  correlator result byte from the upstream dispatcher stage.
REQ-007 rdy  input  1  one-cycle strobe; value is valid while rdy=1.
REQ-008 tx  output  1  UART line: 8N1 framing, idle high.
REQ-009 busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-011 fifo_level  output  3  current FIFO occupancy, 0..4.

Function
REQ-012 SHALL write value into the FIFO on every edge where rdy=1 and the FIFO is not full.
REQ-013 SHALL drop the byte when rdy=1 and the FIFO is full with no pop on the same edge, set overflow=1, and hold overflow until rst.
REQ-014 SHALL accept the write on a simultaneous pop and write when full; fifo_level stays unchanged.
REQ-015 SHALL never pop on an edge where the FIFO is empty; a write on such an edge is not bypassed to the FSM and is popped no earlier than the next edge.
REQ-016 SHALL use a 4-entry circular buffer with 2-bit read/write pointers that wrap 3->0; FIFO order is strictly first in, first out.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; if fifo_level>0, pop the head byte into the shift register on this edge and go to START.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-020 DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, 8 bits, then STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-022 SHALL size the bit counter to count 0..CLKS_PER_BIT-1 and reload it to 0 on every state change.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, from the first tx=0 cycle to the last stop-bit cycle.
REQ-024 Latency: rdy=1 at edge E0 into an idle, empty block SHALL give tx=0 in the cycle after edge E1.
REQ-025 SHALL drive tx from a register (glitch-free, no combinational path from inputs).
REQ-026 SHALL ignore value whenever rdy=0.

Reset
REQ-027 On rst=1 at an edge, SHALL set: tx=1, busy=0, overflow=0, fifo_level=0, pointers=0, FSM=IDLE, counters=0.
REQ-028 rst mid-frame SHALL abort the frame, with tx=1 from the following cycle; queued bytes are discarded.
REQ-029 rdy while rst=1 SHALL be ignored.

Verification (CLKS_PER_BIT=4)
REQ-030 Single byte: rdy pulse with value=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); busy falls after the stop bit; overflow=0.
REQ-031 Back-to-back: pulses with 0x00 then 0xFF on consecutive cycles -> two frames with no idle cycle between the stop bit and the next start; 80 cycles from the first tx=0 to the end of the second stop bit.
REQ-032 Overflow: values 1..6 on 6 consecutive rdy cycles -> fifo_level peaks at 4, byte 6 dropped, overflow=1 and stays 1; frames 0x01..0x05 are transmitted in order.
REQ-033 Full-boundary simultaneity: FIFO full (4) and rdy asserted on the STOP->START pop edge -> write accepted, fifo_level remains 4, overflow unchanged.
REQ-034 Reset mid-frame: rst asserted during DATA bit 3 with 2 bytes queued -> next cycle tx=1, fifo_level=0, busy=0; a following rdy with 0x3C produces a clean 0x3C frame.
REQ-035 Pointer wrap: 10 bytes sent singly with gaps -> all 10 frames are received in order, with no corruption across pointer wrap.

Source files
------------

// File: rtl/corr_uart_tx_if.sv
// corr_uart_tx_if: result-byte strobe in, UART line and status out.
// Master is the upstream dispatcher side, slave is the transmitter.
interface corr_uart_tx_if;
  logic [7:0] value;
  logic       rdy;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_level;

  modport master (
    output value, rdy,
    input  tx, busy, overflow, fifo_level
  );

  modport slave (
    input  value, rdy,
    output tx, busy, overflow, fifo_level
  );
endinterface

// File: rtl/corr_uart_tx.sv
// corr_uart_tx: 4-deep byte FIFO feeding an 8N1 UART transmitter.
// tx is registered; back-to-back frames run with no idle gap.
module corr_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input logic          clk,
  input logic          rst,
  corr_uart_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_q;

  logic [7:0]  mem [4];
  logic [1:0]  wp;
  logic [1:0]  rp;
  logic [2:0]  level;
  logic        ovf;

  logic        cnt_end;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;

  assign cnt_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign empty   = (level == 3'd0);
  assign full    = (level == 3'd4);
  // pop only in IDLE or at the last STOP cycle, never from an empty FIFO
  assign pop     = !empty &&
                   ((state == IDLE) || ((state == STOP) && cnt_end));
  // a full FIFO still accepts when the head leaves on the same edge
  assign push    = bus.rdy && (!full || pop);

  assign bus.tx         = tx_q;
  assign bus.busy       = (state != IDLE) || !empty;
  assign bus.overflow   = ovf;
  assign bus.fifo_level = level;

  // FIFO storage, no reset needed: occupancy is tracked by level
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wp] <= bus.value;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      level <= level + 3'(push) - 3'(pop);
      if (bus.rdy && !push) ovf <= 1'b1;
    end
  end

  // frame FSM; tx is loaded with the value of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          cnt  <= '0;
          if (pop) begin
            shift <= mem[rp];
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (cnt_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_q    <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rp];
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_uart_tx.sv
// tb_corr_uart_tx: directed bench for corr_uart_tx at 4 clocks per bit.
// A negedge line receiver decodes frames into queues for checking.
module tb_corr_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int passed = 0;
  int total  = 0;

  logic [7:0] rx_q [$];
  int         st_q [$];
  logic       ok_q [$];

  corr_uart_tx_if bus();

  corr_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // line receiver: 40 samples per frame, aborts on reset
  initial begin
    logic        act;
    int          n;
    int          st;
    logic [39:0] sb;
    logic [7:0]  d;
    logic        ok;
    act = 1'b0;
    n   = 0;
    st  = 0;
    sb  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        act = 1'b0;
        n   = 0;
      end else begin
        if (!act && bus.tx === 1'b0) begin
          act = 1'b1;
          n   = 0;
          st  = cyc;
        end
        if (act) begin
          sb[n] = bus.tx;
          n++;
          if (n == 40) begin
            ok = 1'b1;
            for (int b = 0; b < 10; b++)
              for (int k = 1; k < 4; k++)
                if (sb[b*4+k] !== sb[b*4]) ok = 1'b0;
            if (sb[0] !== 1'b0)  ok = 1'b0;
            if (sb[36] !== 1'b1) ok = 1'b0;
            for (int b = 0; b < 8; b++) d[b] = sb[4+4*b];
            rx_q.push_back(d);
            st_q.push_back(st);
            ok_q.push_back(ok);
            act = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] v);
    bus.value = v;
    bus.rdy   = 1'b1;
    tick();
    bus.rdy   = 1'b0;
    bus.value = 8'h00;
  endtask

  task automatic wait_frames(input string tag, input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 2000) begin
      tick();
      k++;
    end
    chk({tag, "_count"}, rx_q.size(), n);
  endtask

  task automatic chk_frame(input string tag, input int i,
                           input logic [7:0] exp);
    logic [7:0] d;
    logic       ok;
    d  = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    ok = (i < ok_q.size()) ? ok_q[i] : 1'b0;
    chk({tag, "_data"}, d, exp);
    chk({tag, "_framing"}, ok, 1'b1);
  endtask

  task automatic clear_q();
    rx_q.delete();
    st_q.delete();
    ok_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_q();
  endtask

  initial begin
    int e0;
    logic [7:0] wv [10];
    bus.value = 8'h00;
    bus.rdy   = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_level", bus.fifo_level, 3'd0);
    rst = 1'b0;
    tick();
    clear_q();

    // single byte 0xA5 with latency
    send(8'hA5);
    e0 = cyc;
    chk("a5_tx_e0", bus.tx, 1'b1);
    chk("a5_level_e0", bus.fifo_level, 3'd1);
    chk("a5_busy_e0", bus.busy, 1'b1);
    wait_frames("a5", 1);
    chk_frame("a5", 0, 8'hA5);
    chk("a5_latency", (st_q.size() > 0) ? st_q[0] - e0 : -1, 1);
    chk("a5_busy_end", bus.busy, 1'b0);
    chk("a5_ovf", bus.overflow, 1'b0);
    chk("a5_tx_idle", bus.tx, 1'b1);
    tick();
    tick();
    clear_q();

    // back-to-back 0x00 then 0xFF
    bus.rdy   = 1'b1;
    bus.value = 8'h00;
    tick();
    bus.value = 8'hFF;
    tick();
    bus.rdy   = 1'b0;
    wait_frames("b2b", 2);
    chk_frame("b2b0", 0, 8'h00);
    chk_frame("b2b1", 1, 8'hFF);
    chk("b2b_gap",
        (st_q.size() > 1) ? st_q[1] - st_q[0] : -1, 40);
    chk("b2b_busy_end", bus.busy, 1'b0);
    tick();
    clear_q();

    // overflow: 1..6 on consecutive cycles
    bus.rdy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.value = 8'(i);
      tick();
      if (i == 5) begin
        chk("ovf_level5", bus.fifo_level, 3'd4);
        chk("ovf_flag5", bus.overflow, 1'b0);
      end
    end
    bus.rdy   = 1'b0;
    bus.value = 8'h00;
    chk("ovf_level6", bus.fifo_level, 3'd4);
    chk("ovf_flag6", bus.overflow, 1'b1);
    wait_frames("ovf", 5);
    for (int i = 0; i < 5; i++)
      chk_frame("ovf_frame", i, 8'(i + 1));
    repeat (60) tick();
    chk("ovf_no_sixth", rx_q.size(), 5);
    chk("ovf_sticky", bus.overflow, 1'b1);
    chk("ovf_level_end", bus.fifo_level, 3'd0);
    chk("ovf_busy_end", bus.busy, 1'b0);

    // full FIFO with write on the STOP->START pop edge
    do_reset();
    chk("rst2_ovf", bus.overflow, 1'b0);
    bus.rdy = 1'b1;
    bus.value = 8'h11; tick();
    bus.value = 8'h22; tick();
    bus.value = 8'h33; tick();
    bus.value = 8'h44; tick();
    bus.value = 8'h55; tick();
    bus.rdy = 1'b0;
    chk("full_level", bus.fifo_level, 3'd4);
    repeat (36) tick();
    chk("full_stop_tx", bus.tx, 1'b1);
    chk("full_stop_level", bus.fifo_level, 3'd4);
    bus.rdy   = 1'b1;
    bus.value = 8'h66;
    tick();
    bus.rdy   = 1'b0;
    chk("full_simul_level", bus.fifo_level, 3'd4);
    chk("full_simul_ovf", bus.overflow, 1'b0);
    chk("full_simul_tx", bus.tx, 1'b0);
    wait_frames("full", 6);
    chk_frame("full0", 0, 8'h11);
    chk_frame("full1", 1, 8'h22);
    chk_frame("full2", 2, 8'h33);
    chk_frame("full3", 3, 8'h44);
    chk_frame("full4", 4, 8'h55);
    chk_frame("full5", 5, 8'h66);
    tick();
    clear_q();

    // reset during DATA bit 3 with two bytes queued
    bus.rdy = 1'b1;
    bus.value = 8'hAA; tick();
    bus.value = 8'hBB; tick();
    bus.value = 8'hCC; tick();
    bus.rdy = 1'b0;
    repeat (16) tick();
    chk("mid_level", bus.fifo_level, 3'd2);
    rst       = 1'b1;
    bus.rdy   = 1'b1;
    bus.value = 8'h99;
    tick();
    chk("mid_tx", bus.tx, 1'b1);
    chk("mid_level_rst", bus.fifo_level, 3'd0);
    chk("mid_busy", bus.busy, 1'b0);
    rst     = 1'b0;
    bus.rdy = 1'b0;
    tick();
    chk("mid_rdy_ignored", bus.fifo_level, 3'd0);
    clear_q();
    send(8'h3C);
    wait_frames("mid3c", 1);
    chk_frame("mid3c", 0, 8'h3C);
    repeat (50) tick();
    chk("mid_only_one", rx_q.size(), 1);
    chk("mid_busy_end", bus.busy, 1'b0);
    clear_q();

    // ten single bytes across pointer wrap
    wv = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E,
           8'h00, 8'hFF, 8'h96, 8'h3C, 8'hE1};
    for (int i = 0; i < 10; i++) begin
      send(wv[i]);
      wait_frames("wrap", i + 1);
      repeat (3) tick();
    end
    for (int i = 0; i < 10; i++)
      chk_frame("wrap", i, wv[i]);
    chk("wrap_ovf", bus.overflow, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
